sample_frame_reader: RTL and testbench
======================================

Name: sample_frame_reader

Overview:
Sequences reads of one completed audio frame out of the sample buffer RAM and streams the samples to a downstream consumer (VU meter, filter) over a valid/ready interface. It starts a frame on the buffer-ready pulse from the capture side, generates RAM addresses, absorbs the 1-cycle RAM read latency, and honours consumer backpressure without losing samples. It sits between the sample buffer RAM read port and the audio-processing blocks.

Parameters:
DEPTH, 512, samples per frame; power of two, ≥ 4
ADDR_W, $clog2(DEPTH), RAM address width
DATA_W, 24, sample width (signed two's complement, passed through unmodified)

Ports:
clk_i  in  1  system clock
rst_i  in  1  reset, asynchronous, active-high
buffer_ready_i  in  1  1-cycle pulse: a full frame is stored in the RAM
ram_rd_en_o  out  1  RAM read enable
ram_rd_addr_o  out  ADDR_W  RAM read address
ram_rd_data_i  in  DATA_W  RAM read data, valid exactly 1 cycle after ram_rd_en_o
sample_o  out  DATA_W  sample to consumer
sample_valid_o  out  1  sample_o valid
sample_ready_i  in  1  consumer accepts; transfer = valid && ready
frame_last_o  out  1  qualifies sample_o as sample DEPTH-1 of the frame
busy_o  out  1  frame in progress
overrun_o  out  1  1-cycle pulse: buffer_ready_i arrived while busy
overrun_cnt_o  out  8  saturating count of overruns

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset state: FSM=IDLE; address counter, FIFO and in-flight flag cleared. All outputs 0, including overrun_cnt_o.
- FSM states:
  - IDLE: buffer_ready_i=1 → READ, address counter=0.
  - READ: issues reads at addresses 0..DEPTH-1 in order; after issuing DEPTH-1 → DRAIN.
  - DRAIN: → IDLE once nothing is in flight, the FIFO is empty, and the last sample has been transferred.
- busy_o=1 in READ and DRAIN.
- Output buffer: 2-entry FIFO holding {data, last}.
  - ram_rd_data_i is written in the cycle after a read is issued.
  - sample_o, sample_valid_o and frame_last_o are driven from the FIFO head.
- Read issue rule: ram_rd_en_o=1 in READ only if occupancy + inflight + 1 − pop ≤ 2, where pop = sample_valid_o && sample_ready_i.
  - ram_rd_addr_o holds the current address whenever ram_rd_en_o=1; it is 0 otherwise.
  - The address increments only on issue.
  - A read is never issued unless its data has a guaranteed FIFO slot, so no sample is ever dropped.
- Throughput: 1 sample/cycle when sample_ready_i is held high.
- Latency: pulse sampled at edge t → ram_rd_en_o high with addr 0 in cycle t+1 → data written into the FIFO at the end of t+2 → sample_valid_o=1 in cycle t+3.
- Valid/ready: once sample_valid_o is asserted, sample_o and frame_last_o stay stable until the transfer completes. Valid never depends combinationally on ready.
- frame_last_o is set on exactly one transfer per frame, the one at address DEPTH-1.
- buffer_ready_i while busy_o=1 (including the cycle of the final transfer):
  - the pulse is ignored;
  - overrun_o pulses for 1 cycle;
  - overrun_cnt_o increments and saturates at 255.
- Simultaneous events:
  - buffer_ready_i in the same cycle the FSM returns DRAIN→IDLE counts as an overrun (busy is still 1).
  - The same-cycle FIFO push and pop are legal; occupancy is unchanged.
- Reset mid-frame: the frame is abandoned immediately, FIFO contents are discarded, and no further reads are issued.
- Arithmetic: address counter is ADDR_W wide; there is no wrap within a frame because the exit condition is address == DEPTH-1.

Optional Feature:
SAMPLE_FRAME_READER_PENDING_EN
- Defined: one buffer_ready_i received while busy is latched in a pending flag and still reported via overrun_o and overrun_cnt_o. On DRAIN→IDLE with the flag set, the FSM goes directly to READ with address 0 (no IDLE cycle), and the flag clears. Further pulses while the flag is already set are dropped.
- Undefined: no pending flag exists; pulses received while busy are dropped.

Test Plan:
- DEPTH=8, RAM model holds data = addr×3; pulse buffer_ready_i, sample_ready_i=1 → ram_rd_en_o first at t+1; samples 0,3,…,21 on consecutive cycles starting t+3; frame_last_o only with 21; busy_o low after the last transfer.
- Same frame with sample_ready_i toggling 1,0,0,1 repeatedly → all 8 samples in order with no duplicates or loss; sample_o stable while valid && !ready; ram_rd_en_o never issued when occupancy + inflight = 2 and no pop.
- Pulse buffer_ready_i twice while busy → overrun_o pulses twice; overrun_cnt_o=2; exactly 8 samples.
- 300 overrun pulses → overrun_cnt_o saturates at 255.
- Assert rst_i mid-frame after 3 transfers → all outputs 0 immediately, asynchronously; a new pulse restarts the frame from address 0.
- With SAMPLE_FRAME_READER_PENDING_EN defined: pulse during a frame → 16 samples back-to-back; second frame's ram_rd_en_o asserts in the cycle after DRAIN exit; overrun_cnt_o=1.

Source files
------------

// File: rtl/sample_frame_reader_if.sv
// RAM read port plus sample valid/ready stream of sample_frame_reader.
// master = the reader; slave = RAM and downstream consumer.
interface sample_frame_reader_if #(
   parameter int ADDR_W = 9,
   parameter int DATA_W = 24
);
   logic              ram_rd_en_o;
   logic [ADDR_W-1:0] ram_rd_addr_o;
   logic [DATA_W-1:0] ram_rd_data_i;
   logic [DATA_W-1:0] sample_o;
   logic              sample_valid_o;
   logic              sample_ready_i;
   logic              frame_last_o;

   modport master (
      output ram_rd_en_o, ram_rd_addr_o, sample_o, sample_valid_o, frame_last_o,
      input  ram_rd_data_i, sample_ready_i
   );

   modport slave (
      input  ram_rd_en_o, ram_rd_addr_o, sample_o, sample_valid_o, frame_last_o,
      output ram_rd_data_i, sample_ready_i
   );
endinterface

// File: rtl/sample_frame_reader.sv
// Reads one stored audio frame from the sample RAM and streams it over valid/ready.
// Optional `SAMPLE_FRAME_READER_PENDING_EN latches one early buffer-ready pulse.
module sample_frame_reader #(
   parameter int DEPTH  = 512,
   parameter int ADDR_W = $clog2(DEPTH),
   parameter int DATA_W = 24
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  buffer_ready_i,
   sample_frame_reader_if.master bus,
   output logic                  busy_o,
   output logic                  overrun_o,
   output logic [7:0]            overrun_cnt_o
);

   typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic              last;
   } entry_t;

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   state_t            state_q;
   logic [ADDR_W-1:0] addr_q;
   logic              inflight_q;
   logic              inflight_last_q;
   entry_t            fifo_q [2];
   logic              rd_ptr_q;
   logic              wr_ptr_q;
   logic [1:0]        count_q;
   logic              overrun_q;
   logic [7:0]        ovf_cnt_q;

   logic              pop;
   logic              push;
   logic              rd_en;
   logic [2:0]        need;
   logic [1:0]        count_d;
   logic              busy;
   logic              start;
   logic              drain_done;

`ifdef SAMPLE_FRAME_READER_PENDING_EN
   logic              pend_q;
   assign start = buffer_ready_i || pend_q;
`else
   assign start = buffer_ready_i;
`endif

   always_comb begin
      // NOTE: each always_comb output is assigned unconditionally up front so no latch is inferred.
      pop     = (count_q != 2'd0) && bus.sample_ready_i;
      push    = inflight_q;
      // Issue only when the returning word is guaranteed a FIFO slot.
      need    = 3'(count_q) + 3'(inflight_q) + 3'd1 - 3'(pop);
      rd_en   = (state_q == READ) && (need <= 3'd2);
      count_d = count_q + 2'(push) - 2'(pop);
   end

   assign busy       = (state_q != IDLE);
   assign drain_done = !inflight_q && ((count_q == 2'd0) || ((count_q == 2'd1) && pop));

   assign bus.ram_rd_en_o    = rd_en;
   assign bus.ram_rd_addr_o  = rd_en ? addr_q : '0;
   assign bus.sample_o       = fifo_q[rd_ptr_q].data;
   assign bus.sample_valid_o = (count_q != 2'd0);
   assign bus.frame_last_o   = fifo_q[rd_ptr_q].last;
   assign busy_o             = busy;
   assign overrun_o          = overrun_q;
   assign overrun_cnt_o      = ovf_cnt_q;

   // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q         <= IDLE;
         addr_q          <= '0;
         inflight_q      <= 1'b0;
         inflight_last_q <= 1'b0;
         // NOTE: the two FIFO entries are reset because the head drives sample_o, which must read 0 out of reset.
         fifo_q[0]       <= '0;
         fifo_q[1]       <= '0;
         rd_ptr_q        <= 1'b0;
         wr_ptr_q        <= 1'b0;
         count_q         <= 2'd0;
         overrun_q       <= 1'b0;
         ovf_cnt_q       <= 8'd0;
`ifdef SAMPLE_FRAME_READER_PENDING_EN
         pend_q          <= 1'b0;
`endif
      end else begin
         inflight_q      <= rd_en;
         inflight_last_q <= rd_en && (addr_q == LAST_ADDR);
         if (push) begin
            fifo_q[wr_ptr_q] <= '{data: bus.ram_rd_data_i, last: inflight_last_q};
            wr_ptr_q         <= ~wr_ptr_q;
         end
         if (pop) rd_ptr_q <= ~rd_ptr_q;
         count_q   <= count_d;

         overrun_q <= buffer_ready_i && busy;
         if (buffer_ready_i && busy && (ovf_cnt_q != 8'hFF)) ovf_cnt_q <= ovf_cnt_q + 8'd1;
`ifdef SAMPLE_FRAME_READER_PENDING_EN
         if (buffer_ready_i && busy && !pend_q) pend_q <= 1'b1;
`endif

         case (state_q)
            IDLE: begin
               if (start) begin
                  state_q <= READ;
                  addr_q  <= '0;
`ifdef SAMPLE_FRAME_READER_PENDING_EN
                  pend_q  <= 1'b0;
`endif
               end
            end
            READ: begin
               if (rd_en) begin
                  addr_q <= addr_q + 1'b1;
                  if (addr_q == LAST_ADDR) state_q <= DRAIN;
               end
            end
            DRAIN: begin
               if (drain_done) begin
`ifdef SAMPLE_FRAME_READER_PENDING_EN
                  if (pend_q) begin
                     state_q <= READ;
                     addr_q  <= '0;
                     pend_q  <= 1'b0;
                  end else begin
                     state_q <= IDLE;
                  end
`else
                  state_q <= IDLE;
`endif
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sample_frame_reader.sv
// Self-checking bench for sample_frame_reader: frame-level reference model plus directed literals.
module tb_sample_frame_reader;
  localparam int DEPTH  = 8;
  localparam int ADDR_W = 3;
  localparam int DATA_W = 24;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       buffer_ready = 1'b0;
  logic       busy;
  logic       overrun;
  logic [7:0] ovf_cnt;

  sample_frame_reader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  sample_frame_reader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .buffer_ready_i (buffer_ready),
    .bus            (bus),
    .busy_o         (busy),
    .overrun_o      (overrun),
    .overrun_cnt_o  (ovf_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // RAM with one-cycle read latency
  logic [DATA_W-1:0] ram [DEPTH];
  always @(posedge clk) if (bus.ram_rd_en_o) bus.ram_rd_data_i <= ram[bus.ram_rd_addr_o];

  // consumer: 0 = always ready, 1 = 1,0,0,1 pattern, 2 = random, other = stalled
  int ready_mode = 0;
  int phase = 0;
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0: bus.sample_ready_i = 1'b1;
      1: begin
        bus.sample_ready_i = ((phase % 4) == 0) || ((phase % 4) == 3);
        phase++;
      end
      2: bus.sample_ready_i = ($urandom_range(0, 2) != 0);
      default: bus.sample_ready_i = 1'b0;
    endcase
  end

  // reference model: expected stream of {data,last}, busy/overrun expectations
  typedef struct {
    logic [DATA_W-1:0] d;
    bit                last;
  } exp_t;

  exp_t q[$];
  bit   m_busy = 0;
  bit   m_ovf  = 0;
  int   m_cnt  = 0;
  bit   m_pend = 0;
  int   outstanding = 0;
  int   exp_addr = 0;
  int   xfer_cnt = 0;
  int   ovf_seen = 0;
  int   cyc = 0;
  int   end_cycs[$];
  int   rd0_cycs[$];

  bit                pop, ended, start, relaunch, old_pend;
  bit                prev_valid = 0, prev_ready = 0, prev_last = 0;
  logic [DATA_W-1:0] prev_sample = '0;
  exp_t              e;

  task automatic push_frame();
    for (int a = 0; a < DEPTH; a++) q.push_back('{d: ram[a], last: (a == DEPTH - 1)});
  endtask

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      q.delete();
      m_busy = 0; m_ovf = 0; m_cnt = 0; m_pend = 0;
      outstanding = 0; exp_addr = 0; prev_valid = 0;
    end else begin
      pop   = bus.sample_valid_o && bus.sample_ready_i;
      ended = 0;
      check("busy", busy, m_busy);
      check("overrun", overrun, m_ovf);
      check("overrun_cnt", ovf_cnt, m_cnt);
      if (overrun) ovf_seen++;

      if (prev_valid && !prev_ready) begin
        check("hold_valid", bus.sample_valid_o, 1);
        check("hold_sample", bus.sample_o, prev_sample);
        check("hold_last", bus.frame_last_o, prev_last);
      end

      if (pop) begin
        xfer_cnt++;
        if (q.size() == 0) begin
          check("spurious_xfer", 1, 0);
        end else begin
          e = q.pop_front();
          check("sample", bus.sample_o, e.d);
          check("frame_last", bus.frame_last_o, e.last);
          ended = e.last;
          if (e.last) end_cycs.push_back(cyc);
        end
      end

      if (bus.ram_rd_en_o) begin
        check("rd_room", (outstanding + 1 - int'(pop)) <= 2, 1);
        check("rd_addr", bus.ram_rd_addr_o, exp_addr);
        check("rd_when_busy", m_busy, 1);
        if (bus.ram_rd_addr_o == 0) rd0_cycs.push_back(cyc);
        exp_addr = (exp_addr + 1) % DEPTH;
      end else begin
        check("rd_addr_idle", bus.ram_rd_addr_o, 0);
      end
      outstanding = outstanding + int'(bus.ram_rd_en_o) - int'(pop);

      // next-cycle expectations
      old_pend = m_pend;
      start    = buffer_ready && !m_busy;
      relaunch = 0;
      m_ovf    = buffer_ready && m_busy;
      if (m_ovf && m_cnt < 255) m_cnt++;
`ifdef SAMPLE_FRAME_READER_PENDING_EN
      if (!m_busy && old_pend) start = 1;
      if (start) m_pend = 0;
      if (ended && old_pend) begin
        push_frame();
        m_pend   = 0;
        relaunch = 1;
      end
      if (buffer_ready && m_busy && !old_pend) m_pend = 1;
`endif
      if (start) begin
        push_frame();
        m_busy = 1;
      end
      if (ended && !relaunch) m_busy = 0;

      prev_valid  = bus.sample_valid_o;
      prev_ready  = bus.sample_ready_i;
      prev_sample = bus.sample_o;
      prev_last   = bus.frame_last_o;
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_rd_en"}, bus.ram_rd_en_o, 0);
    check({tag, "_rd_addr"}, bus.ram_rd_addr_o, 0);
    check({tag, "_sample"}, bus.sample_o, 0);
    check({tag, "_valid"}, bus.sample_valid_o, 0);
    check({tag, "_last"}, bus.frame_last_o, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_overrun"}, overrun, 0);
    check({tag, "_cnt"}, ovf_cnt, 0);
  endtask

  task automatic pulse();
    @(posedge clk); #1 buffer_ready = 1'b1;
    @(posedge clk); #1 buffer_ready = 1'b0;
  endtask

  task automatic fill_ramp();
    for (int a = 0; a < DEPTH; a++) ram[a] = DATA_W'(a * 3);
  endtask

  task automatic wait_idle();
    bit done = 0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      if (!m_busy && !m_pend && q.size() == 0 && !busy) begin
        done = 1;
        break;
      end
    end
    if (!done) check("idle_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  // hand-computed timing of one frame with the consumer always ready
  task automatic directed_frame(input string tag);
    pulse();
    check({tag, "_first_rd_en"}, bus.ram_rd_en_o, 1);
    check({tag, "_first_rd_addr"}, bus.ram_rd_addr_o, 0);
    @(posedge clk); #1;
    check({tag, "_valid_t2"}, bus.sample_valid_o, 0);
    @(posedge clk); #1;
    for (int k = 0; k < DEPTH; k++) begin
      check({tag, "_valid_k"}, bus.sample_valid_o, 1);
      check({tag, "_sample_k"}, bus.sample_o, k * 3);
      check({tag, "_last_k"}, bus.frame_last_o, (k == DEPTH - 1));
      @(posedge clk); #1;
    end
    check({tag, "_busy_after"}, busy, 0);
  endtask

  int x0;
  bit got;

  initial begin
    fill_ramp();
    #2;
    check_all_zero("reset");
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    directed_frame("ramp");
    wait_idle();

    ready_mode = 1; phase = 0;
    x0 = xfer_cnt;
    pulse();
    wait_idle();
    check("toggle_xfers", xfer_cnt - x0, DEPTH);

    x0 = xfer_cnt; ovf_seen = 0;
    pulse();
    repeat (3) @(posedge clk);
    pulse();
    repeat (2) @(posedge clk);
    pulse();
    wait_idle();
    check("ovf_cnt_two", ovf_cnt, 2);
    check("ovf_pulses_two", ovf_seen, 2);
`ifdef SAMPLE_FRAME_READER_PENDING_EN
    check("ovf_xfers", xfer_cnt - x0, 2 * DEPTH);
`else
    check("ovf_xfers", xfer_cnt - x0, DEPTH);
`endif

    for (int a = 0; a < DEPTH; a++) ram[a] = DATA_W'($urandom);
    ready_mode = 2;
    for (int i = 0; i < 1500; i++) begin
      @(posedge clk); #1 buffer_ready = ($urandom_range(0, 29) == 0);
    end
    buffer_ready = 1'b0;
    wait_idle();

    ready_mode = 3;
    pulse();
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1 buffer_ready = 1'b1;
      @(posedge clk); #1 buffer_ready = 1'b0;
    end
    check("ovf_saturate", ovf_cnt, 255);
    ready_mode = 0;
    wait_idle();

    fill_ramp();
    x0 = xfer_cnt; got = 0;
    pulse();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); #1;
      if (xfer_cnt >= x0 + 3) begin
        got = 1;
        break;
      end
    end
    if (!got) check("mid_reset_timeout", 0, 1);
    #2 rst = 1'b1;
    #1 check_all_zero("async_reset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    directed_frame("restart");
    wait_idle();

`ifdef SAMPLE_FRAME_READER_PENDING_EN
    end_cycs.delete(); rd0_cycs.delete();
    x0 = xfer_cnt;
    pulse();
    repeat (3) @(posedge clk);
    pulse();
    wait_idle();
    check("pend_xfers", xfer_cnt - x0, 2 * DEPTH);
    check("pend_cnt", ovf_cnt, 1);
    if (end_cycs.size() >= 1 && rd0_cycs.size() >= 2)
      check("pend_restart_gap", rd0_cycs[1] - end_cycs[0], 1);
    else
      check("pend_restart_seen", 0, 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
